inst_axi_bridge: RTL and testbench

INST_AXI_BRIDGE -- requirements
Module: inst_axi_bridge

---
 rtl/inst_axi_bridge.sv | 121 ++++++++++++
 tb/tb_inst_axi_bridge.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_axi_bridge.sv
// -----------------------------------------------------------------------------
// inst_axi_bridge
// Adapts the CPU instruction-fetch SRAM-like interface to an AXI read channel.
// One fetch is in flight at a time; each becomes a single-beat INCR read.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   inst_sram_*           fetch request (en/addr/size) and response
//                         (addr_ok/data_ok/rdata); wr/wen/wdata are ignored
//   inst_err              bus error, pulses with inst_sram_data_ok
//   fetch_cancel          drop the result of the outstanding fetch
//   ar*                   AXI read-address channel (master side)
//   r*                    AXI read-data channel (master side)
// -----------------------------------------------------------------------------
module inst_axi_bridge #(
  parameter logic [3:0] ARID = 4'h0
) (
  input  logic        clk,
  input  logic        reset,
  // Fetch interface
  input  logic        inst_sram_en,
  input  logic        inst_sram_wr,
  input  logic [3:0]  inst_sram_wen,
  input  logic [31:0] inst_sram_wdata,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic        inst_err,
  input  logic        fetch_cancel,
  // AXI AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic        arvalid,
  input  logic        arready,
  // AXI R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [1:0] {StIdle, StAr, StR} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [29:0] r_addr;     // word address; byte offset is always dropped on AR
  logic [1:0]  r_size;
  logic        r_cancel;
  logic        w_beat_done;

  // Write-side fetch inputs and the byte offset have no use on a read-only path.
  logic w_unused;
  assign w_unused = ^{inst_sram_wr, inst_sram_wen, inst_sram_wdata, inst_sram_addr[1:0]};

  // Only the last beat carrying our own ID ends the transaction.
  assign w_beat_done = (r_state == StR) && rvalid && rlast && (rid == ARID);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= StIdle;
      r_addr   <= '0;
      r_size   <= '0;
      r_cancel <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (inst_sram_addr_ok) begin
        r_addr <= inst_sram_addr[31:2];
        r_size <= inst_sram_size;
      end
      // Returning to idle wins, so a cancel that coincides with completion
      // cannot leak into the next fetch.
      if (w_state_next == StIdle) begin
        r_cancel <= 1'b0;
      end else if (r_state != StIdle && fetch_cancel) begin
        r_cancel <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next      = r_state;
    inst_sram_addr_ok = 1'b0;
    arvalid           = 1'b0;
    rready            = 1'b0;
    unique case (r_state)
      StIdle: begin
        inst_sram_addr_ok = inst_sram_en && !fetch_cancel;
        if (inst_sram_en && !fetch_cancel) w_state_next = StAr;
      end
      StAr: begin
        arvalid = 1'b1;
        if (arready) w_state_next = StR;
      end
      StR: begin
        rready = 1'b1;
        if (w_beat_done) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
    if (reset) w_state_next = StIdle;
  end

  // AR fields come straight from the latched request, so they hold until arready.
  assign arid    = ARID;
  assign araddr  = {r_addr, 2'b00};
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, r_size};
  assign arburst = 2'b01;

  assign inst_sram_data_ok = w_beat_done && !r_cancel && !fetch_cancel;
  assign inst_sram_rdata   = rdata;
  assign inst_err          = inst_sram_data_ok && (rresp != 2'b00);

endmodule

// File: tb/tb_inst_axi_bridge.sv
// -----------------------------------------------------------------------------
// tb_inst_axi_bridge
// Directed bench for inst_axi_bridge. Stimulus pushes expected fetch results
// into a scoreboard queue; a monitor pops and compares on every data_ok.
// -----------------------------------------------------------------------------
module tb_inst_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_en, inst_sram_wr;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_wdata;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok, inst_sram_data_ok, inst_err;
  logic [31:0] inst_sram_rdata;
  logic        fetch_cancel;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;

  always #5 clk = ~clk;

  inst_axi_bridge dut (
    .clk               (clk),
    .reset             (reset),
    .inst_sram_en      (inst_sram_en),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_wen     (inst_sram_wen),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .inst_err          (inst_err),
    .fetch_cancel      (fetch_cancel),
    .arid              (arid),
    .araddr            (araddr),
    .arlen             (arlen),
    .arsize            (arsize),
    .arburst           (arburst),
    .arvalid           (arvalid),
    .arready           (arready),
    .rid               (rid),
    .rdata             (rdata),
    .rresp             (rresp),
    .rlast             (rlast),
    .rvalid            (rvalid),
    .rready            (rready)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp);
    rvalid = 1'b1;
    rlast  = 1'b1;
    rid    = id;
    rdata  = data;
    rresp  = resp;
  endtask

  task automatic r_idle;
    rvalid = 1'b0;
    rlast  = 1'b0;
    rid    = 4'h0;
    rdata  = 32'h0;
    rresp  = 2'b00;
  endtask

  // Full fetch: accept, AR held for ar_wait stalled cycles, one R beat.
  task automatic fetch(input logic [31:0] addr, input int ar_wait,
                       input logic [31:0] data, input logic [1:0] resp);
    next_cyc;
    inst_sram_en   = 1'b1;
    inst_sram_addr = addr;
    inst_sram_size = 2'd2;
    sample;
    chk("addr_ok_idle", inst_sram_addr_ok, 1);
    for (int i = 0; i <= ar_wait; i++) begin
      next_cyc;
      inst_sram_addr = 32'h0;  // latched copy must be used from here on
      arready        = (i == ar_wait);
      sample;
      chk("arvalid_ar", arvalid, 1);
      chk("araddr", araddr, addr & 32'hffff_fffc);
      chk("addr_ok_ar", inst_sram_addr_ok, 0);
      if (i == 0) begin
        chk("arsize", arsize, 3'b010);
        chk("arlen", arlen, 0);
        chk("arburst", arburst, 2'b01);
        chk("arid", arid, 0);
      end
    end
    next_cyc;
    inst_sram_en = 1'b0;
    arready      = 1'b0;
    r_beat(4'h0, data, resp);
    sb_q.push_back('{data: data, err: (resp != 2'b00)});
    sample;
    chk("rready_r", rready, 1);
    chk("data_ok_latency", inst_sram_data_ok, 1);
    chk("inst_err_direct", inst_err, (resp != 2'b00));
    chk("arvalid_r", arvalid, 0);
    next_cyc;
    r_idle;
    sample;
    chk("rready_back_idle", rready, 0);
    chk("arvalid_back_idle", arvalid, 0);
  endtask

  // Accept a request and hand AR over immediately; returns at the end of the AR cycle.
  task automatic enter_r(input logic [31:0] addr);
    next_cyc;
    inst_sram_en   = 1'b1;
    inst_sram_addr = addr;
    inst_sram_size = 2'd2;
    sample;
    chk("enter_addr_ok", inst_sram_addr_ok, 1);
    next_cyc;
    inst_sram_en = 1'b0;
    arready      = 1'b1;
    sample;
    chk("enter_arvalid", arvalid, 1);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (inst_sram_data_ok === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_data_ok: got data_ok=1 rdata=0x%08h, expected no response at %0t",
                 inst_sram_rdata, $time);
      end else begin
        e = sb_q.pop_front();
        chk("sb_rdata", inst_sram_rdata, e.data);
        chk("sb_inst_err", inst_err, e.err);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  initial begin
    reset           = 1'b1;
    inst_sram_en    = 1'b0;
    inst_sram_wr    = 1'b0;
    inst_sram_wen   = 4'h0;
    inst_sram_wdata = 32'h0;
    inst_sram_size  = 2'd0;
    inst_sram_addr  = 32'h0;
    fetch_cancel    = 1'b0;
    arready         = 1'b0;
    r_idle;

    next_cyc;
    next_cyc;
    sample;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_data_ok", inst_sram_data_ok, 0);
    chk("rst_inst_err", inst_err, 0);

    // rvalid while idle is not consumed
    next_cyc;
    reset = 1'b0;
    r_beat(4'h0, 32'h5555_aaaa, 2'b00);
    sample;
    chk("idle_rready", rready, 0);
    chk("idle_data_ok", inst_sram_data_ok, 0);
    chk("idle_addr_ok_no_en", inst_sram_addr_ok, 0);

    // Cancel blocks acceptance in idle
    next_cyc;
    r_idle;
    inst_sram_en = 1'b1;
    fetch_cancel = 1'b1;
    sample;
    chk("cancel_blocks_addr_ok", inst_sram_addr_ok, 0);
    next_cyc;
    inst_sram_en = 1'b0;
    fetch_cancel = 1'b0;
    sample;
    chk("cancel_no_state_change", arvalid, 0);

    fetch(32'hbfc0_0000, 0, 32'h3c1d_bfc0, 2'b00);
    fetch(32'hbfc0_0006, 3, 32'h1234_5678, 2'b00);
    fetch(32'hbfc0_0010, 0, 32'hdead_beef, 2'b10);

    // Cancel in R, beat arrives two cycles later and is swallowed
    enter_r(32'hbfc0_0020);
    next_cyc;
    arready      = 1'b0;
    fetch_cancel = 1'b1;
    sample;
    chk("cancel_r_rready", rready, 1);
    next_cyc;
    fetch_cancel = 1'b0;
    sample;
    chk("cancel_r_wait", rready, 1);
    next_cyc;
    r_beat(4'h0, 32'haaaa_5555, 2'b10);
    sample;
    chk("cancel_beat_rready", rready, 1);
    chk("cancel_beat_data_ok", inst_sram_data_ok, 0);
    chk("cancel_beat_err", inst_err, 0);
    next_cyc;
    r_idle;
    sample;
    chk("cancel_back_idle", rready, 0);
    fetch(32'hbfc0_0024, 0, 32'h1111_2222, 2'b00);

    // Cancel on the completing beat itself
    enter_r(32'hbfc0_0028);
    next_cyc;
    arready      = 1'b0;
    fetch_cancel = 1'b1;
    r_beat(4'h0, 32'h7777_8888, 2'b00);
    sample;
    chk("same_cycle_cancel_data_ok", inst_sram_data_ok, 0);
    next_cyc;
    fetch_cancel = 1'b0;
    r_idle;
    sample;
    chk("same_cycle_cancel_idle", rready, 0);

    // Foreign ID beat is consumed, then our beat completes
    enter_r(32'hbfc0_002c);
    next_cyc;
    arready = 1'b0;
    r_beat(4'h1, 32'hbad0_bad0, 2'b00);
    sample;
    chk("foreign_rready", rready, 1);
    chk("foreign_data_ok", inst_sram_data_ok, 0);
    next_cyc;
    r_beat(4'h0, 32'h0bad_f00d, 2'b00);
    sb_q.push_back('{data: 32'h0bad_f00d, err: 1'b0});
    sample;
    chk("own_id_data_ok", inst_sram_data_ok, 1);
    next_cyc;
    r_idle;
    sample;
    chk("own_id_back_idle", rready, 0);

    // Reset while in R abandons the read
    enter_r(32'hbfc0_0030);
    next_cyc;
    arready      = 1'b0;
    reset        = 1'b1;
    inst_sram_en = 1'b1;
    sample;
    next_cyc;
    reset = 1'b0;
    sample;
    chk("rst_mid_arvalid", arvalid, 0);
    chk("rst_mid_rready", rready, 0);
    chk("rst_mid_addr_ok", inst_sram_addr_ok, 1);
    // That request was accepted; drop it with another reset pulse
    next_cyc;
    reset        = 1'b1;
    inst_sram_en = 1'b0;
    next_cyc;
    reset = 1'b0;
    sample;
    chk("rst_again_arvalid", arvalid, 0);

    fetch(32'hbfc0_0040, 1, 32'hcafe_f00d, 2'b00);

    next_cyc;
    next_cyc;
    chk("scoreboard_drained", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
